seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the 7-segment display driver.
- Samples the multiplexed `led_segment`/`dis_sel` scan bus and reconstructs the 8 displayed digits as BCD.
- Flags blanked and blinking digits and reports complete scan frames.
- Used in-system for display read-back/self-check and in benches as a scoreboard front end for the display path.

Parameters:
- SEG_ACT_LOW, 1, 1 = segment lit when `led_segment` bit is 0.
- SEL_ACT_LOW, 1, 1 = digit selected when `dis_sel` bit is 0.
- SETTLE_CYC, 4, consecutive cycles a select/segment pair must be stable before capture (1..15).
- TIMEOUT_CYC, 100000, cycles without any capture before scan is declared lost (counter is 20 bits wide).

Ports:
- clk  in  1  system clock; both scan inputs are synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- led_segment  in  7  segment bus; bit0 = a … bit6 = g.
- dis_sel  in  8  digit select; bit i selects digit i.
- digits_out  out  32  digit i in [4i+3:4i]; 0-9 = BCD, 4'hF = blank, 4'hE = unrecognised pattern.
- blank_mask  out  8  bit i = digit i was blank in last frame.
- blink_mask  out  8  bit i = blank status of digit i differed between the last two frames.
- frame_valid  out  1  one-cycle pulse when `digits_out`, `blank_mask` and `blink_mask` update.
- seg_err  out  1  one-cycle pulse when a captured pattern decodes to 4'hE.
- sel_err  out  1  one-cycle pulse when a select value with ≥2 active bits has been stable SETTLE_CYC cycles.
- scan_lost  out  1  level; high after timeout, low on next capture.

Behaviour:
- Inputs are registered once. Polarity is normalised by the parameters to active-high `seg_n[6:0]` and `sel_n[7:0]`.
- Decode table (gfedcba, lit = 1): 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110, 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
  - All off → 4'hF (blank).
  - Any other pattern → 4'hE.
  - 6 and 9 also accepted without segment a (6) / segment d (9).
- Per-digit capture FSM: states IDLE, SETTLE, HELD.
  - IDLE: `sel_n` one-hot → SETTLE with `stab_cnt` = 1 and the (`sel`, `seg`) pair recorded. `sel_n` zero → stay IDLE. `sel_n` multi-hot → SETTLE as well, for `sel_err` timing only.
  - SETTLE: if the pair changes, restart with the new pair, `stab_cnt` = 1. When `stab_cnt` reaches SETTLE_CYC:
    - One-hot select: write the decoded value into `buf[i]`, set `seen[i]`, → HELD.
    - Multi-hot select: pulse `sel_err` and go to HELD with no capture.
  - HELD: stays HELD while the pair is unchanged. Any change → IDLE if `sel_n` is zero, otherwise SETTLE with the new pair.
  - A digit is therefore captured at most once per select dwell.
- Frame assembly:
  - When the capture sets the last missing `seen` bit (`seen` becomes 8'hFF), the outputs update on the next cycle:
    - `digits_out` ← `buf`.
    - `blank_mask` ← per-digit (`buf` == F).
    - `blink_mask` ← new `blank_mask` XOR previous `blank_mask`.
    - `frame_valid` pulses.
  - `seen` clears to 0 in that same update cycle.
  - Re-capturing an already-seen digit before the frame completes overwrites `buf[i]` without a frame.
  - First frame after reset: previous `blank_mask` = 0.
- `seg_err` pulses in the cycle of the capture that produced 4'hE. The frame still completes with E in that digit.
- Timeout:
  - `to_cnt` increments every cycle and clears on each capture.
  - At TIMEOUT_CYC: `scan_lost` ← 1, `seen` ← 0, `to_cnt` saturates.
  - Next capture: `scan_lost` ← 0.
- Reset (async, any time, including mid-frame or mid-settle):
  - FSM → IDLE; `seen`, `buf`, counters → 0.
  - `digits_out` = 32'hFFFF_FFFF.
  - `blank_mask` = 8'hFF; `blink_mask` = 0.
  - `frame_valid` = `seg_err` = `sel_err` = `scan_lost` = 0.
- Latency: capture occurs 1 (input register) + SETTLE_CYC cycles after the pair first appears; outputs update 1 cycle after the last capture.

Test Plan:
- Time frame:
  - Stimulus: scan digits 0..7 showing 1,2,3,4,5,6,7,8, 20 cycles each, active-low encoding.
  - Required: exactly one `frame_valid` per full scan; `digits_out` = 32'h87654321; `blank_mask` = 0.
- Blink:
  - Stimulus: alternate frames with digits 2,3 blank (all segments off) and showing "4","5".
  - Required: `blank_mask` alternates 8'h0C / 8'h00; `blink_mask` = 8'h0C from the second frame onward.
- Glitch/settle:
  - Stimulus: a 2-cycle spurious pattern at each select transition, with SETTLE_CYC = 4.
  - Required: no capture of the glitch; `digits_out` unchanged from the clean-scan value.
- Errors:
  - Stimulus: segment pattern 1000000 on digit 5 → required `seg_err` pulse and `digits_out[23:20]` = E.
  - Stimulus: `dis_sel` with two active bits held 10 cycles → required single `sel_err` pulse and no `frame_valid`.
- Timeout:
  - Stimulus: TIMEOUT_CYC = 100; stop scanning after 5 digits.
  - Required: `scan_lost` = 1 at cycle 100 after the last capture. After scanning resumes, the first `frame_valid` requires all 8 digits re-seen.
- Reset mid-frame:
  - Stimulus: assert `rst` after 4 digit captures, then release and complete the scan.
  - Required: immediate reset values (`digits_out` = FFFFFFFF, `blank_mask` = FF); no `frame_valid` until 8 fresh captures.

Source files
------------

// File: rtl/seg_scan_decoder_if.sv
// Scan-bus interface for the 7-segment read-back decoder.
interface seg_scan_decoder_if;
  logic [6:0]  led_segment;
  logic [7:0]  dis_sel;
  logic [31:0] digits_out;
  logic [7:0]  blank_mask;
  logic [7:0]  blink_mask;
  logic        frame_valid;
  logic        seg_err;
  logic        sel_err;
  logic        scan_lost;

  // Display driver side: drives the scan bus, observes the decoded result.
  modport master (
    output led_segment, dis_sel,
    input  digits_out, blank_mask, blink_mask, frame_valid, seg_err, sel_err, scan_lost
  );

  // Decoder side: samples the scan bus, produces the decoded result.
  modport slave (
    input  led_segment, dis_sel,
    output digits_out, blank_mask, blink_mask, frame_valid, seg_err, sel_err, scan_lost
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Reconstructs the 8 displayed digits from a multiplexed 7-segment scan bus.
module seg_scan_decoder #(
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          SEL_ACT_LOW = 1'b1,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_decoder_if.slave scan
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TO_W  = 20;
  localparam int unsigned NDIG  = 8;

  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYC);
  localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_CYC);
  localparam logic [3:0]       D_BLANK    = 4'hF;
  localparam logic [3:0]       D_ERR      = 4'hE;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t                state, state_nxt;
  logic [6:0]            seg_n;
  logic [7:0]            sel_n;
  logic [6:0]            pair_seg, pair_seg_nxt;
  logic [7:0]            pair_sel, pair_sel_nxt;
  logic [CNT_W-1:0]      stab_cnt, stab_cnt_nxt, cnt_try;
  logic                  pair_changed, sel_onehot;
  logic                  capture_c, sel_err_c, frame_done_c, to_hit_c;
  logic [3:0]            seg_dec_c;
  logic [2:0]            cap_idx_c;
  logic [NDIG-1:0][3:0]  dig_buf;
  logic [NDIG-1:0]       seen;
  logic [TO_W-1:0]       to_cnt;
  logic [NDIG-1:0]       blank_c, blank_prev;
  logic [31:0]           digits_q;
  logic [7:0]            blank_q, blink_q;
  logic                  frame_valid_q, seg_err_q, sel_err_q, scan_lost_q;

  // Segment pattern (gfedcba, lit = 1) to BCD; F = blank, E = unrecognised.
  function automatic logic [3:0] decode_seg(input logic [6:0] s);
    case (s)
      7'h00:        decode_seg = D_BLANK;
      7'h3F:        decode_seg = 4'd0;
      7'h06:        decode_seg = 4'd1;
      7'h5B:        decode_seg = 4'd2;
      7'h4F:        decode_seg = 4'd3;
      7'h66:        decode_seg = 4'd4;
      7'h6D:        decode_seg = 4'd5;
      7'h7D, 7'h7C: decode_seg = 4'd6;
      7'h07:        decode_seg = 4'd7;
      7'h7F:        decode_seg = 4'd8;
      7'h6F, 7'h67: decode_seg = 4'd9;
      default:      decode_seg = D_ERR;
    endcase
  endfunction

  // Index of the active bit of a one-hot select.
  function automatic logic [2:0] sel_index(input logic [7:0] s);
    sel_index = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (s[i]) sel_index = 3'(i);
    end
  endfunction

  // Register the scan bus once and normalise both buses to active-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n <= '0;
      sel_n <= '0;
    end else begin
      seg_n <= SEG_ACT_LOW ? ~scan.led_segment : scan.led_segment;
      sel_n <= SEL_ACT_LOW ? ~scan.dis_sel : scan.dis_sel;
    end
  end

  assign pair_changed = (sel_n != pair_sel) || (seg_n != pair_seg);
  assign sel_onehot   = (sel_n != '0) && ((sel_n & (sel_n - 8'd1)) == '0);
  assign cnt_try      = (state == SETTLE && !pair_changed) ? stab_cnt + CNT_W'(1) : CNT_W'(1);
  assign seg_dec_c    = decode_seg(seg_n);
  assign cap_idx_c    = sel_index(sel_n);

  // Capture FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture FSM next state: a pair is captured once after SETTLE_CYC stable cycles.
  always_comb begin
    state_nxt    = state;
    pair_sel_nxt = pair_sel;
    pair_seg_nxt = pair_seg;
    stab_cnt_nxt = stab_cnt;
    capture_c    = 1'b0;
    sel_err_c    = 1'b0;
    if (sel_n == '0) begin
      state_nxt    = IDLE;
      stab_cnt_nxt = '0;
    end else if (state != HELD || pair_changed) begin
      pair_sel_nxt = sel_n;
      pair_seg_nxt = seg_n;
      stab_cnt_nxt = cnt_try;
      if (cnt_try == SETTLE_MAX) begin
        state_nxt = HELD;
        capture_c = sel_onehot;
        sel_err_c = !sel_onehot;
      end else begin
        state_nxt = SETTLE;
      end
    end
  end

  // Tracked select/segment pair and its stability count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_sel <= '0;
      pair_seg <= '0;
      stab_cnt <= '0;
    end else begin
      pair_sel <= pair_sel_nxt;
      pair_seg <= pair_seg_nxt;
      stab_cnt <= stab_cnt_nxt;
    end
  end

  assign frame_done_c = (seen == '1);
  assign to_hit_c     = !capture_c && (to_cnt != TO_MAX) && ((to_cnt + TO_W'(1)) == TO_MAX);

  // Digit buffer, seen tracking, error pulses and scan-loss timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_buf     <= '0;
      seen        <= '0;
      to_cnt      <= '0;
      scan_lost_q <= 1'b0;
      seg_err_q   <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      seg_err_q <= capture_c && (seg_dec_c == D_ERR);
      sel_err_q <= sel_err_c;
      if (capture_c) begin
        dig_buf[cap_idx_c] <= seg_dec_c;
        seen               <= (frame_done_c ? '0 : seen) | sel_n;
      end else if (frame_done_c || to_hit_c) begin
        seen <= '0;
      end
      if (capture_c) begin
        to_cnt      <= '0;
        scan_lost_q <= 1'b0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TO_W'(1);
        if (to_hit_c) scan_lost_q <= 1'b1;
      end
    end
  end

  // Per-digit blank flags of the buffered frame.
  always_comb begin
    blank_c = '0;
    for (int i = 0; i < NDIG; i++) begin
      blank_c[i] = (dig_buf[i] == D_BLANK);
    end
  end

  // Publish a completed frame the cycle after its last capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q      <= '1;
      blank_q       <= '1;
      blink_q       <= '0;
      blank_prev    <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= frame_done_c;
      if (frame_done_c) begin
        digits_q   <= dig_buf;
        blank_q    <= blank_c;
        blink_q    <= blank_c ^ blank_prev;
        blank_prev <= blank_c;
      end
    end
  end

  assign scan.digits_out  = digits_q;
  assign scan.blank_mask  = blank_q;
  assign scan.blink_mask  = blink_q;
  assign scan.frame_valid = frame_valid_q;
  assign scan.seg_err     = seg_err_q;
  assign scan.sel_err     = sel_err_q;
  assign scan.scan_lost   = scan_lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder against a dwell-level reference model.
module tb_seg_scan_decoder;

  localparam int unsigned S  = 4;
  localparam int unsigned TO = 100;

  typedef struct {
    int          cyc;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic [7:0]  blink;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  seg_scan_decoder_if bus();

  seg_scan_decoder #(
    .SEG_ACT_LOW (1'b1),
    .SEL_ACT_LOW (1'b1),
    .SETTLE_CYC  (S),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .scan (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: gfedcba patterns for 0..9, digit buffer, seen set.
  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [3:0] m_buf [8];
  logic [7:0] m_seen = '0;
  logic [7:0] m_prev = '0;
  frame_t     exp_q[$];
  frame_t     f;
  int         exp_seg_err = 0, exp_sel_err = 0;
  int         got_seg_err = 0, got_sel_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] model_decode(input logic [6:0] seg);
    if (seg == 7'h00) return 4'hF;
    for (int d = 0; d < 10; d++) if (pat[d] == seg) return 4'(d);
    if (seg == (pat[6] & ~7'h01)) return 4'd6;
    if (seg == (pat[9] & ~7'h08)) return 4'd9;
    return 4'hE;
  endfunction

  // One dwell of a (select, segment) pair held for n cycles, starting at cycle c0.
  function automatic void model_dwell(input logic [7:0] sel, input logic [6:0] seg,
                                      input int n, input int c0);
    int          idx;
    logic [3:0]  d;
    frame_t      fr;
    if (sel == 8'h00 || n < int'(S)) return;
    if ($countones(sel) > 1) begin
      exp_sel_err++;
      return;
    end
    idx = 0;
    for (int i = 0; i < 8; i++) if (sel[i]) idx = i;
    d = model_decode(seg);
    if (d == 4'hE) exp_seg_err++;
    m_buf[idx]  = d;
    m_seen[idx] = 1'b1;
    if (m_seen == 8'hFF) begin
      for (int i = 0; i < 8; i++) begin
        fr.digits[4*i +: 4] = m_buf[i];
        fr.blank[i]         = (m_buf[i] == 4'hF);
      end
      fr.blink = fr.blank ^ m_prev;
      fr.cyc   = c0 + int'(S) + 2;
      m_prev   = fr.blank;
      m_seen   = '0;
      exp_q.push_back(fr);
    end
  endfunction

  // Drive an active-high logical pair onto the active-low bus for n cycles.
  task automatic drive(input logic [7:0] sel, input logic [6:0] seg, input int n);
    bus.dis_sel     = ~sel;
    bus.led_segment = ~seg;
    model_dwell(sel, seg, n, cyc);
    repeat (n) @(negedge clk);
  endtask

  // Show a BCD value (or F for blank) on digit i.
  task automatic show(input int i, input logic [3:0] val, input int n);
    logic [6:0] seg;
    seg = (val == 4'hF) ? 7'h00 : pat[val];
    drive(8'b1 << i, seg, n);
  endtask

  task automatic end_phase(input string name);
    drive(8'h00, 7'h00, 12);
    check({name, "_frames_pending"}, 32'(exp_q.size()), 32'd0);
    check({name, "_seg_err_cnt"}, 32'(got_seg_err), 32'(exp_seg_err));
    check({name, "_sel_err_cnt"}, 32'(got_sel_err), 32'(exp_sel_err));
    exp_q.delete();
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    #1;
    check({name, "_digits"}, bus.digits_out, 32'hFFFF_FFFF);
    check({name, "_blank"}, 32'(bus.blank_mask), 32'h0000_00FF);
    check({name, "_blink"}, 32'(bus.blink_mask), 32'd0);
    check({name, "_flags"}, {28'd0, bus.frame_valid, bus.seg_err, bus.sel_err, bus.scan_lost}, 32'd0);
    bus.dis_sel     = 8'hFF;
    bus.led_segment = 7'h7F;
    m_seen = '0;
    m_prev = '0;
    for (int i = 0; i < 8; i++) m_buf[i] = 4'h0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Frame / pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bus.frame_valid) begin
        if (exp_q.size() == 0) begin
          check("frame_extra", 32'(bus.frame_valid), 32'd0);
        end else begin
          f = exp_q.pop_front();
          check("frame_cycle", 32'(cyc), 32'(f.cyc));
          check("frame_digits", bus.digits_out, f.digits);
          check("frame_blank", 32'(bus.blank_mask), 32'(f.blank));
          check("frame_blink", 32'(bus.blink_mask), 32'(f.blink));
        end
      end
      if (bus.seg_err) got_seg_err++;
      if (bus.sel_err) got_sel_err++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         c_last;
    int         target;
    logic [6:0] seg, g;
    int         r, a, b;

    bus.dis_sel     = 8'hFF;
    bus.led_segment = 7'h7F;
    @(negedge clk);
    do_reset("reset");
    mon_en = 1'b1;

    // Clean scan showing 1..8.
    for (int i = 0; i < 8; i++) show(i, 4'(i + 1), 20);
    end_phase("time_frame");

    // Digits 2,3 alternate between blank and "4","5".
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++)
        if (i == 2 || i == 3) show(i, (k % 2 == 0) ? 4'hF : 4'(i + 2), 20);
        else                  show(i, 4'(i), 20);
    end_phase("blink");

    // 2-cycle spurious pattern at every select transition.
    for (int i = 0; i < 8; i++) begin
      drive(8'b1 << i, ~pat[i + 1], 2);
      show(i, 4'(i + 1), 20);
    end
    end_phase("glitch");

    // Unrecognised pattern on digit 5, then a two-hot select held 10 cycles.
    for (int i = 0; i < 8; i++)
      if (i == 5) drive(8'b1 << i, 7'h40, 20);
      else        show(i, 4'(i + 1), 20);
    drive(8'h24, pat[3], 10);
    end_phase("errors");

    // Stop after 5 digits; scan_lost must rise exactly TO cycles after the last capture.
    for (int i = 0; i < 4; i++) show(i, 4'(i), 20);
    c_last = cyc;
    show(4, 4'd4, 20);
    bus.dis_sel     = 8'hFF;
    bus.led_segment = 7'h7F;
    target = c_last + 1 + int'(S) + int'(TO) - 1;
    while (cyc < target) @(negedge clk);
    check("timeout_before", 32'(bus.scan_lost), 32'd0);
    @(negedge clk);
    check("timeout_at", 32'(bus.scan_lost), 32'd1);
    repeat (5) @(negedge clk);
    m_seen = '0;
    show(5, 4'd5, 20);
    check("scan_lost_clear", 32'(bus.scan_lost), 32'd0);
    show(6, 4'hF, 20);
    show(7, 4'hF, 20);
    for (int i = 0; i < 5; i++) show(i, 4'(i), 20);
    end_phase("timeout");

    // Reset after 4 captures; a fresh scan in a different order must need all 8.
    for (int i = 0; i < 4; i++) show(i, 4'(9 - i), 20);
    do_reset("rst_mid");
    for (int j = 0; j < 8; j++) show((j + 4) % 8, 4'((j + 4) % 8), 20);
    end_phase("rst_mid");

    // Randomised scans: glitches, short dwells, gaps, bad patterns, multi-hot selects.
    for (int fr = 0; fr < 15; fr++) begin
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 11);
        if (r < 10)       seg = pat[r];
        else if (r == 10) seg = 7'h00;
        else              seg = 7'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          g = 7'($urandom);
          if (g == seg) g = ~seg;
          drive(8'b1 << i, g, $urandom_range(1, 3));
        end
        if ($urandom_range(0, 9) == 0) drive(8'h00, 7'h00, $urandom_range(1, 4));
        if ($urandom_range(0, 15) == 0) begin
          a = $urandom_range(0, 7);
          b = (a + $urandom_range(1, 7)) % 8;
          drive((8'b1 << a) | (8'b1 << b), seg, $urandom_range(2, 8));
        end
        drive(8'b1 << i, seg, $urandom_range(2, 24));
      end
    end
    end_phase("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
